// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   dm_state_t      - FSM state encodings (DM_IDLE, DM_WAIT, DM_ACCESS)
//   DM_SIZE_BYTE/WORD - access size codes carried on the size strobe
//   lane_enable()   - big-endian byte-write enable for a given size/offset
//   load_extract()  - lane select and sign extension for load results
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_WAIT   = 2'd1,
        DM_ACCESS = 2'd2
    } dm_state_t;

    localparam logic DM_SIZE_BYTE = 1'b0;
    localparam logic DM_SIZE_WORD = 1'b1;

    // Offset 0 is the most significant byte, so enable bit 3 covers [31:24].
    function automatic logic [3:0] lane_enable(input logic size, input logic [1:0] offset);
        if (size == DM_SIZE_WORD)
            return 4'b1111;
        return 4'b1000 >> offset;
    endfunction

    function automatic logic [31:0] load_extract(input logic size, input logic [1:0] offset,
                                                 input logic [31:0] word);
        logic [7:0] lane;
        case (offset)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        if (size == DM_SIZE_WORD)
            return word;
        return {{24{lane[7]}}, lane};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Strobe interface between the multicycle controller/datapath and the
// data-memory responder.
//   dm_read, dm_write - request strobes (controller -> memory)
//   size              - 0 byte, 1 word
//   addr, wdata       - byte address and store data
//   rdata             - sign-extended load result
//   done, busy, err   - completion pulse, in-flight flag, error pulse
interface dmem_responder_if;
    logic        dm_read;
    logic        dm_write;
    logic        size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;

    modport master (
        output dm_read, dm_write, size, addr, wdata,
        input  rdata, done, busy, err
    );

    modport slave (
        input  dm_read, dm_write, size, addr, wdata,
        output rdata, done, busy, err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and combinational read.
// Contents are not reset.
//   clk   - write clock
//   be    - byte-write enables, bit 3 = [31:24]
//   addr  - word index
//   wdata - write data (only enabled lanes are stored)
//   rdata - combinational read of addr
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i])
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per request, waits
// WAIT_CYCLES, then performs a big-endian byte or word access and pulses done.
//   clk   - system clock
//   reset - asynchronous, active-low
//   bus   - slave side of dmem_responder_if
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   DM_IDLE   | waiting for a strobe; also the cycle in which done is high
//   DM_WAIT   | counting down wait states for the latched request
//   DM_ACCESS | legality check, array access, raise done (and err)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [29:0] WORD_LIM  = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    dm_state_t   state;
    logic [3:0]  cnt;
    logic        is_write_q;
    logic        size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        busy_q;
    logic        err_q;

    logic        legal;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_word;

    assign legal = (addr_q[31:2] < WORD_LIM) &&
                   !(size_q == DM_SIZE_WORD && addr_q[1:0] != 2'd0);

    // Write enables are gated by the live state so an async reset before
    // ACCESS can never let a pending store reach the array.
    assign wr_be   = (state == DM_ACCESS && is_write_q && legal) ?
                     lane_enable(size_q, addr_q[1:0]) : 4'b0000;
    assign wr_data = (size_q == DM_SIZE_WORD) ? wdata_q : {4{wdata_q[7:0]}};

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .be    (wr_be),
        .addr  (addr_q[AW+1:2]),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DM_IDLE;
            cnt        <= 4'd0;
            is_write_q <= 1'b0;
            size_q     <= DM_SIZE_BYTE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                DM_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.dm_read && bus.dm_write) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (bus.dm_read || bus.dm_write) begin
                        is_write_q <= bus.dm_write;
                        size_q     <= bus.size;
                        addr_q     <= bus.addr;
                        wdata_q    <= bus.wdata;
                        cnt        <= WAIT_INIT;
                        busy_q     <= 1'b1;
                        state      <= (WAIT_CYCLES > 0) ? DM_WAIT : DM_ACCESS;
                    end
                end
                DM_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1)
                        state <= DM_ACCESS;
                end
                DM_ACCESS: begin
                    done_q <= 1'b1;
                    state  <= DM_IDLE;
                    if (!legal)
                        err_q <= 1'b1;
                    else if (!is_write_q)
                        rdata_q <= load_extract(size_q, addr_q[1:0], rd_word);
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule
